// File: rtl/txt_ctrl_pkg.sv
// txt_ctrl_pkg: parser states, screen geometry, clear command byte and blank character shared by text_write_ctrl
package txt_ctrl_pkg;
  typedef enum logic [2:0] {S_COL, S_ROW, S_CHAR, S_TERM, S_CLEAR} state_e;
  localparam int SCR_COLS = 80;
  localparam int SCR_ROWS = 30;
  localparam int COL_W = 7;
  localparam int ROW_W = 5;
  localparam int CHAR_W = 7;
  localparam int BYTE_W = 8;
  localparam logic [BYTE_W-1:0] CLEAR_CMD = 8'hFF;
  localparam logic [CHAR_W-1:0] CLEAR_CHAR = 7'h20;
endpackage

// File: rtl/rx_byte_fifo.sv
// rx_byte_fifo: byte FIFO (ports: push_i/data_i in, pop_i/data_o out, full_o, empty_o, overflow_o flags a dropped push)
module rx_byte_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o,
  output logic         overflow_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign empty_o = cnt_q == '0;
  assign full_o = cnt_q == (AW+1)'(DEPTH);
  assign do_pop = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign overflow_o = push_i && full_o && !do_pop;
  assign data_o = mem_q[rp_q];
  always_ff @(posedge clk_i)
    if (do_push) mem_q[wp_q] <= data_i;
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q == AW'(DEPTH - 1) ? '0 : wp_q + 1'b1;
      if (do_pop) rp_q <= rp_q == AW'(DEPTH - 1) ? '0 : rp_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/text_write_ctrl.sv
// text_write_ctrl: UART bytes (rx_valid_i/rx_data_i) -> cell-write frames and clear engine on the buffer port (wr_en_o/col_w_o/row_w_o/din_o), busy_o during clear, err_o pulse; TXT_CTRL_TIMEOUT_EN adds an inter-byte timeout
module text_write_ctrl #(
  parameter int N_COL = txt_ctrl_pkg::SCR_COLS,
  parameter int N_ROW = txt_ctrl_pkg::SCR_ROWS,
  parameter int N_COL_WIDTH = txt_ctrl_pkg::COL_W,
  parameter int N_ROW_WIDTH = txt_ctrl_pkg::ROW_W,
  parameter int N_CHARS_WIDTH = txt_ctrl_pkg::CHAR_W,
  parameter int UART_DATA_WIDTH = txt_ctrl_pkg::BYTE_W,
  parameter logic [N_CHARS_WIDTH-1:0] CLEAR_CHAR = txt_ctrl_pkg::CLEAR_CHAR,
  parameter int TIMEOUT_CYCLES = 250000
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       rx_valid_i,
  input  logic [UART_DATA_WIDTH-1:0] rx_data_i,
  output logic                       wr_en_o,
  output logic [N_COL_WIDTH-1:0]     col_w_o,
  output logic [N_ROW_WIDTH-1:0]     row_w_o,
  output logic [N_CHARS_WIDTH-1:0]   din_o,
  output logic                       busy_o,
  output logic                       err_o
);
  import txt_ctrl_pkg::*;
  state_e state_q, state_d;
  logic rxv_q, ferr_q, ferr_d;
  logic [N_COL_WIDTH-1:0] fcol_q, fcol_d, ccol_q, ccol_d, col_d, ccur;
  logic [N_ROW_WIDTH-1:0] frow_q, frow_d, crow_q, crow_d, row_d, rcur;
  logic [N_CHARS_WIDTH-1:0] din_d;
  logic [UART_DATA_WIDTH-1:0] b, bcol;
  logic wr_en_d, busy_d, err_d, empty, full, ovf, pop, clr_go, last, row_bad;
  rx_byte_fifo #(.W(UART_DATA_WIDTH), .DEPTH(2)) u_fifo (
    .clk_i(clk_i),
    .rstn_i(rstn_i),
    .push_i(rx_valid_i && !rxv_q),
    .pop_i(pop),
    .data_i(rx_data_i),
    .data_o(b),
    .full_o(full),
    .empty_o(empty),
    .overflow_o(ovf)
  );
  assign pop = !empty && state_q != S_CLEAR;
  assign clr_go = pop && state_q == S_COL && b == CLEAR_CMD;
  assign ccur = state_q == S_CLEAR ? ccol_q : '0;
  assign rcur = state_q == S_CLEAR ? crow_q : '0;
  assign last = ccur == N_COL_WIDTH'(N_COL - 1) && rcur == N_ROW_WIDTH'(N_ROW - 1);
  assign bcol = b >= UART_DATA_WIDTH'(N_COL) ? b - UART_DATA_WIDTH'(N_COL) : b;
  assign row_bad = (b >> N_ROW_WIDTH) != '0 || b[N_ROW_WIDTH-1:0] >= N_ROW_WIDTH'(N_ROW);
`ifdef TXT_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_q;
  logic tmo;
  assign tmo = idle_q == TW'(TIMEOUT_CYCLES);
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) idle_q <= '0;
    else idle_q <= (empty && !tmo && state_q inside {S_ROW, S_CHAR, S_TERM}) ? idle_q + TW'(1) : '0;
`endif
  always_comb begin
    state_d = state_q;
    ferr_d = ferr_q;
    fcol_d = fcol_q;
    frow_d = frow_q;
    ccol_d = ccol_q;
    crow_d = crow_q;
    col_d = col_w_o;
    row_d = row_w_o;
    din_d = din_o;
    wr_en_d = 1'b0;
    busy_d = 1'b0;
    err_d = ovf;
    if (state_q == S_CLEAR || clr_go) begin
      wr_en_d = 1'b1;
      busy_d = 1'b1;
      col_d = ccur;
      row_d = rcur;
      din_d = CLEAR_CHAR;
      ccol_d = ccur == N_COL_WIDTH'(N_COL - 1) ? '0 : ccur + 1'b1;
      crow_d = ccur == N_COL_WIDTH'(N_COL - 1) ? rcur + 1'b1 : rcur;
      state_d = (state_q == S_CLEAR && last) ? S_TERM : S_CLEAR;
    end else if (pop) begin
      case (state_q)
        S_COL: begin
          fcol_d = N_COL_WIDTH'(bcol);
          ferr_d = b[UART_DATA_WIDTH-1];
          state_d = S_ROW;
        end
        S_ROW: begin
          frow_d = b[N_ROW_WIDTH-1:0];
          ferr_d = ferr_q || row_bad;
          state_d = S_CHAR;
        end
        S_CHAR: begin
          wr_en_d = !ferr_q;
          err_d = ovf || ferr_q;
          col_d = ferr_q ? col_w_o : fcol_q;
          row_d = ferr_q ? row_w_o : frow_q;
          din_d = ferr_q ? din_o : b[N_CHARS_WIDTH-1:0];
          state_d = S_TERM;
        end
        default: begin
          ferr_d = 1'b0;
          state_d = S_COL;
        end
      endcase
    end
`ifdef TXT_CTRL_TIMEOUT_EN
    if (tmo) begin
      state_d = S_COL;
      ferr_d = 1'b0;
      err_d = 1'b1;
    end
`endif
  end
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      state_q <= S_COL;
      rxv_q <= 1'b0;
      ferr_q <= 1'b0;
      fcol_q <= '0;
      frow_q <= '0;
      ccol_q <= '0;
      crow_q <= '0;
      wr_en_o <= 1'b0;
      col_w_o <= '0;
      row_w_o <= '0;
      din_o <= '0;
      busy_o <= 1'b0;
      err_o <= 1'b0;
    end else begin
      state_q <= state_d;
      rxv_q <= rx_valid_i;
      ferr_q <= ferr_d;
      fcol_q <= fcol_d;
      frow_q <= frow_d;
      ccol_q <= ccol_d;
      crow_q <= crow_d;
      wr_en_o <= wr_en_d;
      col_w_o <= col_d;
      row_w_o <= row_d;
      din_o <= din_d;
      busy_o <= busy_d;
      err_o <= err_d;
    end
endmodule

// File: doc/text_write_ctrl.md
# text_write_ctrl

Sequences all writes into the character screen buffer. It parses the UART byte stream into cell-write frames and runs a clear-screen engine that fills every cell with a blank character. It owns the buffer write port (`wr_en`, `col_w`, `row_w`, `din`) and sits between the UART receiver and the text buffer in the top level. Bytes that arrive while a clear is running are queued in a small FIFO, so no valid frame is lost.

## Interface
Parameters:
- `N_COL`, 80: screen columns.
- `N_ROW`, 30: screen rows.
- `N_COL_WIDTH`, 7: column index width.
- `N_ROW_WIDTH`, 5: row index width.
- `N_CHARS_WIDTH`, 7: character code width.
- `UART_DATA_WIDTH`, 8: UART byte width.
- `CLEAR_CHAR`, 7'h20: code written by the clear engine.
- `TIMEOUT_CYCLES`, 250000: inter-byte timeout, 10 ms at 25 MHz. Used only when `TXT_CTRL_TIMEOUT_EN` is defined.

Ports:
- `clk_i`, in, 1: 25 MHz pixel clock, single clock domain.
- `rstn_i`, in, 1: reset, asynchronous, active-low.
- `rx_valid_i`, in, 1: UART data-valid level; its rising edge marks a new byte.
- `rx_data_i`, in, 8: UART byte, stable while `rx_valid_i` is high.
- `wr_en_o`, out, 1: buffer write strobe.
- `col_w_o`, out, 7: write column.
- `row_w_o`, out, 5: write row.
- `din_o`, out, 7: write character.
- `busy_o`, out, 1: clear engine is active.
- `err_o`, out, 1: one-cycle error pulse.

## Operation
- Edge detect: a registered copy of `rx_valid_i` is kept. On `!q && rx_valid_i`, `rx_data_i` is pushed into a 2-entry FIFO.
- The parser pops at most one byte per cycle, and only when the FIFO is non-empty and the state is not S_CLEAR.
- Frame format: column, row, character, terminator. The terminator value is ignored.
- States: S_COL, S_ROW, S_CHAR, S_TERM, S_CLEAR.
- S_COL, byte b:
  - b == 8'hFF: go to S_CLEAR.
  - b[7] == 0: col = (b ≥ 80) ? b−80 : b, then go to S_ROW.
  - Any other byte with b[7] = 1: set the frame-error flag, then go to S_ROW.
- S_ROW: row = b[4:0]. If b[7:5] ≠ 0 or row ≥ N_ROW, set the frame-error flag. Go to S_CHAR.
- S_CHAR:
  - Frame-error flag clear: issue a write with din = b[6:0].
  - Frame-error flag set: suppress the write and pulse `err_o`.
  - Either way, go to S_TERM.
- S_TERM: discard the byte, clear the frame-error flag, go to S_COL.
- S_CLEAR:
  - One write per cycle, row-major from (0,0) to (N_COL−1, N_ROW−1), din = CLEAR_CHAR, for 2400 writes in total.
  - After the final write, go to S_TERM, which consumes the clear command's terminator.
- FIFO overflow: a push while the FIFO is full and not popping drops the new byte and pulses `err_o`. Push and pop in the same cycle are always accepted.
- Reset values:
  - All outputs 0.
  - State S_COL, FIFO empty, frame-error flag 0, edge register 0.
  - Asserting reset mid-clear aborts the clear; cells already written stay written.

## Timing
- A rising edge sampled in cycle N is pushed at the end of cycle N and popped in N+1.
- A write byte produces `wr_en_o` = 1 in N+2 with registered `col_w_o`, `row_w_o` and `din_o`. `wr_en_o` is high for exactly one cycle per frame.
- `busy_o` rises the cycle after the 8'hFF pop, together with the first clear write.
- `busy_o` falls the cycle after the last clear write. `wr_en_o` stays high for 2400 consecutive cycles.
- Addresses hold their last value when `wr_en_o` = 0.
- An `err_o` pulse is registered and lasts 1 cycle. Multiple error causes in the same cycle produce a single pulse.

## Configuration
- `TXT_CTRL_TIMEOUT_EN` defined:
  - An idle counter runs while the state is S_ROW, S_CHAR or S_TERM and the FIFO is empty. A pop resets it.
  - When the counter reaches TIMEOUT_CYCLES: return to S_COL, clear the frame-error flag, pulse `err_o`.
  - The counter is held at 0 in S_COL and S_CLEAR.
- Not defined: no counter is present, and the parser waits indefinitely for the next byte.

## Structure
- Package `txt_ctrl_pkg` holds:
  - The state enum.
  - Screen geometry localparams.
  - `CLEAR_CMD` = 8'hFF.
  - `CLEAR_CHAR`.
- Sub-module `rx_byte_fifo`: parameterised depth-2 byte FIFO with push, pop, full, empty and overflow outputs.

## Test plan
- Frame 0x05, 0x03, 0x41, 0x0A → one `wr_en_o` pulse with col 5, row 3, din 0x41, two cycles after the third byte's edge.
- Column byte 0x55 → `col_w_o` = 5.
- Row byte 0x1E → `err_o` pulse and no write; the following frame 0x00, 0x00, 0x42, 0x0A writes (0,0) with 0x42.
- Bytes 0xFF, 0x0A → 2400 consecutive writes of 0x20, the last at (79,29). `busy_o` is high for exactly 2400 cycles.
- Clear command with a full frame streamed at maximum rate during the clear → the frame is written after the clear and no error occurs. Forcing three bytes into the FIFO → `err_o` pulse and the third byte dropped.
- With `TXT_CTRL_TIMEOUT_EN`: send only 0x05, then idle TIMEOUT_CYCLES → `err_o` pulse; the next 4-byte frame is written correctly. Also assert `rstn_i` mid-clear → outputs 0 and `busy_o` = 0 immediately.
